// File: rtl/func_pkg.sv
// Shared widths, FSM state encoding and operand/result records for the func root engine.
package func_pkg;
  localparam int A_W    = 8;
  localparam int Y_W    = 5;
  localparam int BUSY_W = 2;

  typedef enum logic [2:0] {IDLE, START, ACK, BUSY, DONE} state_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
  } req_t;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
  } rsp_t;
endpackage

// File: rtl/func_req_fifo.sv
// Synchronous DEPTH-entry operand FIFO; head data is combinational, occupancy updates one cycle after push/pop.
// Push is ignored while full and pop while empty; a simultaneous push and pop leaves occupancy unchanged.
module func_req_fifo
  import func_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_t                   wr_dat,
  input  logic                   pop,
  output req_t                   rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/func_initiator.sv
// Queues operand pairs, runs them one at a time through func's start/busy handshake and
// returns each result on a valid/ready port; a new op starts only when the response slot is free.
module func_initiator
  import func_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [A_W-1:0]         req_a_bi,
  input  logic [A_W-1:0]         req_b_bi,
  output logic [A_W-1:0]         f_a_bo,
  output logic [A_W-1:0]         f_b_bo,
  output logic                   f_start_o,
  input  logic [BUSY_W-1:0]      f_busy_bi,
  input  logic [Y_W-1:0]         f_y_bi,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [Y_W-1:0]         rsp_y_bo,
  output logic [A_W-1:0]         rsp_a_bo,
  output logic [A_W-1:0]         rsp_b_bo,
  output logic [$clog2(DEPTH):0] pending_o
);
  localparam int          CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] ack_cnt;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          slot_free;
  req_t          head;
  req_t          op_q;
  rsp_t          rsp_q;

  func_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (req_valid_i),
    .wr_dat ({req_a_bi, req_b_bi}),
    .pop    (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (pending_o)
  );

  assign req_ready_o = ~fifo_full;
  assign slot_free   = ~rsp_valid_o | rsp_ready_i;
  assign f_start_o   = (state == START) & ~rst_i;
  assign f_a_bo      = op_q.a;
  assign f_b_bo      = op_q.b;
  assign rsp_y_bo    = rsp_q.y;
  assign rsp_a_bo    = rsp_q.a;
  assign rsp_b_bo    = rsp_q.b;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (~fifo_empty & slot_free) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = ACK;
      // A func that never raises busy is treated as having finished immediately.
      ACK: begin
        if (f_busy_bi != '0)         state_nxt = BUSY;
        else if (ack_cnt == TO_LAST) state_nxt = DONE;
      end
      BUSY: if (f_busy_bi == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ack_cnt     <= '0;
      op_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == START)    ack_cnt <= '0;
      else if (state == ACK) ack_cnt <= ack_cnt + 1'b1;
      if (pop) op_q <= head;
      // DONE is only reached after IDLE saw a free slot, so no unread response is overwritten.
      if (state == DONE) begin
        rsp_q.y     <= f_y_bi;
        rsp_q.a     <= op_q.a;
        rsp_q.b     <= op_q.b;
        rsp_valid_o <= 1'b1;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_func_initiator.sv
// Bench for func_initiator with a behavioral func responder of programmable busy latency.
module tb_func_initiator;
  typedef struct packed {
    logic [4:0] y;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] y;
    logic [2:0] pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] f_a;
  logic [7:0] f_b;
  logic       f_start;
  logic [1:0] f_busy;
  logic [4:0] f_y;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [4:0] rsp_y;
  logic [7:0] rsp_a;
  logic [7:0] rsp_b;
  logic [2:0] pending;

  int   tests = 0;
  int   fails = 0;
  int   n_start = 0;
  exp_t sb[$];

  int         lat = 3;
  logic       force_en = 1'b0;
  logic [4:0] force_y = '0;
  int         busy_left;

  func_initiator #(.DEPTH(4), .ACK_TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_bi    (req_a),
    .req_b_bi    (req_b),
    .f_a_bo      (f_a),
    .f_b_bo      (f_b),
    .f_start_o   (f_start),
    .f_busy_bi   (f_busy),
    .f_y_bi      (f_y),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_y_bo    (rsp_y),
    .rsp_a_bo    (rsp_a),
    .rsp_b_bo    (rsp_b),
    .pending_o   (pending)
  );

  always #5 clk = ~clk;

  function automatic int icbrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [4:0] fmodel(input logic [7:0] a, input logic [7:0] b);
    return 5'(isqrt(int'(a) + icbrt(int'(b))));
  endfunction

  // Behavioral func: busy for lat cycles after start, result held until the next start.
  always @(posedge clk) begin
    if (rst_i) begin
      busy_left <= 0;
      f_y       <= '0;
    end else if (f_start) begin
      busy_left <= lat;
      f_y       <= force_en ? force_y : fmodel(f_a, f_b);
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign f_busy = (busy_left != 0) ? 2'd1 : 2'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Response monitor: scoreboard compare on every handshake plus stability while stalled.
  initial begin
    logic        held;
    logic [20:0] held_dat;
    exp_t        e;
    held = 1'b0;
    held_dat = '0;
    forever begin
      @(negedge clk);
      #1;
      if (f_start) n_start++;
      if (rst_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_data", 32'({rsp_y, rsp_a, rsp_b}), 32'(held_dat));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got y=%0d a=%0d b=%0d, expected no response", rsp_y, rsp_a, rsp_b);
          end else begin
            e = sb.pop_front();
            check("rsp_order_data", 32'({rsp_y, rsp_a, rsp_b}), 32'(e));
          end
        end
        held = rsp_valid && !rsp_ready;
        held_dat = {rsp_y, rsp_a, rsp_b};
      end
    end
  end

  // Drives one request from a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [4:0] y);
    int n = 0;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("push_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{y: y, a: a, b: b});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic measure(output int k);
    int n = 0;
    while (!f_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"}, 32'(req_ready), 32'd1);
    check({p, "_f_start"}, 32'(f_start), 32'd0);
    check({p, "_f_ab"}, 32'({f_a, f_b}), 32'd0);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, "_rsp_yab"}, 32'({rsp_y, rsp_a, rsp_b}), 32'd0);
    check({p, "_pending"}, 32'(pending), 32'd0);
  endtask

  initial begin
    vec_t v[5];
    int   k;
    int   s0;
    v[0] = '{a: 8'd0,   b: 8'd0,   y: 5'd0,  pend: 3'd1};
    v[1] = '{a: 8'd1,   b: 8'd1,   y: 5'd1,  pend: 3'd1};
    v[2] = '{a: 8'd12,  b: 8'd60,  y: 5'd3,  pend: 3'd2};
    v[3] = '{a: 8'd123, b: 8'd223, y: 5'd11, pend: 3'd3};
    v[4] = '{a: 8'd255, b: 8'd255, y: 5'd16, pend: 3'd4};

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // 1: single op, start timing and L+3 response latency
    lat = 5;
    s0 = n_start;
    push(8'd12, 8'd60, 5'd3);
    check("t1_start_early", 32'(f_start), 32'd0);
    check("t1_pending_push", 32'(pending), 32'd1);
    @(negedge clk);
    check("t1_start", 32'(f_start), 32'd1);
    check("t1_pending_pop", 32'(pending), 32'd0);
    check("t1_f_ab", 32'({f_a, f_b}), 32'({8'd12, 8'd60}));
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", 32'(k), 32'd8);
    check("t1_rsp", 32'({rsp_y, rsp_a, rsp_b}), 32'({5'd3, 8'd12, 8'd60}));
    drain("t1");
    check("t1_pending_end", 32'(pending), 32'd0);
    check("t1_start_count", 32'(n_start - s0), 32'd1);

    // 2: burst from the vector table, occupancy after each push
    lat = 10;
    for (int i = 0; i < 5; i++) begin
      push(v[i].a, v[i].b, v[i].y);
      check($sformatf("t2_pending_%0d", i), 32'(pending), 32'(v[i].pend));
    end
    check("t2_ready_full", 32'(req_ready), 32'd0);
    drain("t2");

    // 3: downstream stall holds one response and blocks further starts
    lat = 2;
    rsp_ready = 1'b0;
    s0 = n_start;
    push(8'd40, 8'd8, fmodel(8'd40, 8'd8));
    push(8'd90, 8'd30, fmodel(8'd90, 8'd30));
    push(8'd200, 8'd200, fmodel(8'd200, 8'd200));
    repeat (30) @(negedge clk);
    check("t3_held_valid", 32'(rsp_valid), 32'd1);
    check("t3_held_data", 32'({rsp_y, rsp_a, rsp_b}), 32'({fmodel(8'd40, 8'd8), 8'd40, 8'd8}));
    check("t3_one_start", 32'(n_start - s0), 32'd1);
    check("t3_pending", 32'(pending), 32'd2);
    rsp_ready = 1'b1;
    drain("t3");

    // 4: busy never rises, completion by timeout
    lat = 0;
    force_en = 1'b1;
    force_y = 5'd7;
    push(8'd5, 8'd6, 5'd7);
    measure(k);
    check("t4_timeout_latency", 32'(k), 32'd6);
    check("t4_rsp_y", 32'(rsp_y), 32'd7);
    drain("t4");
    force_en = 1'b0;

    // 5: fill the FIFO behind a stalled response; pushes while full are refused
    lat = 1;
    rsp_ready = 1'b0;
    push(8'd9, 8'd8, fmodel(8'd9, 8'd8));
    push(8'd16, 8'd27, fmodel(8'd16, 8'd27));
    push(8'd30, 8'd64, fmodel(8'd30, 8'd64));
    push(8'd99, 8'd125, fmodel(8'd99, 8'd125));
    push(8'd77, 8'd1, fmodel(8'd77, 8'd1));
    repeat (8) @(negedge clk);
    check("t5_full_ready", 32'(req_ready), 32'd0);
    check("t5_full_pending", 32'(pending), 32'd4);
    req_valid = 1'b1;
    req_a = 8'hAA;
    req_b = 8'h55;
    repeat (5) @(negedge clk);
    check("t5_refused_pending", 32'(pending), 32'd4);
    check("t5_refused_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    push(8'd144, 8'd8, fmodel(8'd144, 8'd8));
    drain("t5");
    check("t5_pending_end", 32'(pending), 32'd0);

    // 6: reset while func is busy; stale result must never surface
    lat = 15;
    push(8'd200, 8'd100, fmodel(8'd200, 8'd100));
    k = 0;
    while (f_busy == 2'd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_busy_seen", 32'(f_busy != 2'd0), 32'd1);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset("t6");
    sb.delete();
    rst_i = 1'b0;
    s0 = n_start;
    repeat (25) @(negedge clk);
    check("t6_no_stale_valid", 32'(rsp_valid), 32'd0);
    check("t6_no_start", 32'(n_start - s0), 32'd0);
    lat = 4;
    push(8'd50, 8'd27, 5'd7);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
